// File: rtl/voq_sched_if.sv
// Switch-side bundle for the VOQ crossbar scheduler: VOQ status in, read and mux controls out.
interface voq_sched_if #(
    parameter int PORT_NUB = 4
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB);

    logic [PORT_NUB*PORT_NUB-1:0]  req;
    logic [PORT_NUB-1:0]           eop;
    logic [PORT_NUB-1:0]           out_ready;
    logic [PORT_NUB-1:0]           rd_en;
    logic [PORT_NUB*WIDTH_SEL-1:0] rd_sel;
    logic [PORT_NUB*WIDTH_SEL-1:0] mux_sel;
    logic [PORT_NUB-1:0]           out_valid;

    modport master (
        output req, eop, out_ready,
        input  rd_en, rd_sel, mux_sel, out_valid
    );

    modport slave (
        input  req, eop, out_ready,
        output rd_en, rd_sel, mux_sel, out_valid
    );
endinterface

// File: rtl/voq_sched.sv
// Packet-granular crossbar scheduler: per-output round-robin over inputs, a rotating
// output-priority pointer to settle input conflicts, and grants held until end of packet.
module voq_sched #(
    parameter int PORT_NUB = 4
) (
    input  logic        clk,
    input  logic        rst,
    voq_sched_if.slave  sw
);
    localparam int WIDTH_SEL = $clog2(PORT_NUB);

    typedef logic [WIDTH_SEL-1:0] sel_t;
    typedef enum logic {IDLE, BUSY} state_e;

    state_e state_q  [PORT_NUB];
    state_e state_d  [PORT_NUB];
    sel_t   gnt_q    [PORT_NUB];
    sel_t   gnt_d    [PORT_NUB];
    sel_t   rr_ptr_q [PORT_NUB];
    sel_t   rr_ptr_d [PORT_NUB];
    sel_t   out_ptr_q;

    logic [PORT_NUB-1:0]           locked;
    logic [PORT_NUB-1:0]           taken;
    logic                          found;
    sel_t                          o_idx;
    sel_t                          i_idx;
    logic [PORT_NUB-1:0]           rd_en_c;
    logic [PORT_NUB-1:0]           out_valid_c;
    logic [PORT_NUB*WIDTH_SEL-1:0] rd_sel_c;
    logic [PORT_NUB*WIDTH_SEL-1:0] mux_sel_c;

    // An input stays locked for as long as any output holds a grant on it.
    always_comb begin
        locked = '0;
        for (int o = 0; o < PORT_NUB; o++) begin
            if (state_q[o] == BUSY) begin
                locked[gnt_q[o]] = 1'b1;
            end
        end
    end

    // Datapath controls depend only on registered state and out_ready.
    always_comb begin
        rd_en_c     = '0;
        rd_sel_c    = '0;
        out_valid_c = '0;
        mux_sel_c   = '0;
        for (int o = 0; o < PORT_NUB; o++) begin
            mux_sel_c[o*WIDTH_SEL +: WIDTH_SEL] = gnt_q[o];
            if (state_q[o] == BUSY) begin
                out_valid_c[o]                                     = sw.out_ready[o];
                rd_en_c[gnt_q[o]]                                  = sw.out_ready[o];
                rd_sel_c[int'(gnt_q[o])*WIDTH_SEL +: WIDTH_SEL]    = sel_t'(o);
            end
        end
    end

    assign sw.rd_en     = rd_en_c;
    assign sw.rd_sel    = rd_sel_c;
    assign sw.out_valid = out_valid_c;
    assign sw.mux_sel   = mux_sel_c;

    // Outputs are visited from out_ptr upward; each idle, ready output takes the first
    // free requesting input from its own rr_ptr, and 'taken' keeps later outputs off it.
    always_comb begin
        taken = '0;
        found = 1'b0;
        o_idx = '0;
        i_idx = '0;
        for (int o = 0; o < PORT_NUB; o++) begin
            state_d[o]  = state_q[o];
            gnt_d[o]    = gnt_q[o];
            rr_ptr_d[o] = rr_ptr_q[o];
        end
        for (int k = 0; k < PORT_NUB; k++) begin
            o_idx = out_ptr_q + sel_t'(k);
            if (state_q[o_idx] == IDLE) begin
                if (sw.out_ready[o_idx]) begin
                    found = 1'b0;
                    for (int j = 0; j < PORT_NUB; j++) begin
                        i_idx = rr_ptr_q[o_idx] + sel_t'(j);
                        if (!found && sw.req[int'(o_idx)*PORT_NUB + int'(i_idx)] &&
                            !locked[i_idx] && !taken[i_idx]) begin
                            found          = 1'b1;
                            taken[i_idx]   = 1'b1;
                            state_d[o_idx] = BUSY;
                            gnt_d[o_idx]   = i_idx;
                        end
                    end
                end
            end else if (rd_en_c[gnt_q[o_idx]] && sw.eop[gnt_q[o_idx]]) begin
                state_d[o_idx]  = IDLE;
                rr_ptr_d[o_idx] = gnt_q[o_idx] + sel_t'(1);
            end
        end
    end

    for (genvar gi = 0; gi < PORT_NUB; gi++) begin : g_out
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q[gi]  <= IDLE;
                gnt_q[gi]    <= '0;
                rr_ptr_q[gi] <= '0;
            end else begin
                state_q[gi]  <= state_d[gi];
                gnt_q[gi]    <= gnt_d[gi];
                rr_ptr_q[gi] <= rr_ptr_d[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_ptr_q <= '0;
        end else begin
            out_ptr_q <= out_ptr_q + sel_t'(1);
        end
    end
endmodule
